step_nn_seq: RTL and testbench

- Parametrised, time-multiplexed successor to the 2-2-1 step-detection datapath.
- Classifies one accelerometer sample pair (A, B) per transaction through H hidden nodes, then one output node and a threshold activation.
- Adds programmable weights, a valid/ready input handshake, step debouncing and a saturating step counter.
- Sits between the sample front-end and the step-count register file.

---
 rtl/step_nn_pkg.sv | 29 ++
 rtl/step_nn_mac.sv | 21 ++
 rtl/step_nn_seq.sv | 182 ++++++++++++++++++
 tb/tb_step_nn_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_nn_pkg.sv
// Shared types and helpers for the time-multiplexed step-detection network.
// Holds the sequencer states, the weight-map layout and the hidden-node activation.
package step_nn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        L1,
        L2,
        ACT
    } state_t;

    // The weight map is three banks of H entries. Bank base = slot * H.
    localparam int WA_SLOT = 0;
    localparam int WB_SLOT = 1;
    localparam int AL_SLOT = 2;

    // ReLU followed by saturation to the largest positive W-bit value.
    function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (v < 64'sd0) begin
            return 64'sd0;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/step_nn_mac.sv
// Combinational signed multiply-add a*x + b*y.
// Both products are full 2W wide and are sign-extended into the accumulator width.
module step_nn_mac #(
    parameter int W     = 8,
    parameter int ACC_W = 2 * W + 4
) (
    input  logic signed [W-1:0]     a_i,
    input  logic signed [W-1:0]     x_i,
    input  logic signed [W-1:0]     b_i,
    input  logic signed [W-1:0]     y_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [2*W-1:0] p0;
    logic signed [2*W-1:0] p1;

    assign p0    = a_i * x_i;
    assign p1    = b_i * y_i;
    assign sum_o = ACC_W'(p0) + ACC_W'(p1);

endmodule

// File: rtl/step_nn_seq.sv
// Time-multiplexed H-hidden-node step classifier with programmable weights,
// valid/ready input, step debouncing and a saturating step counter.
module step_nn_seq
    import step_nn_pkg::*;
#(
    parameter int                      W       = 8,
    parameter int                      H       = 2,
    parameter int                      ACC_W   = 2 * W + 4,
    parameter int                      FRAC    = 0,
    parameter logic signed [ACC_W-1:0] THRESH  = '0,
    parameter int                      MIN_GAP = 4,
    parameter int                      CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [W-1:0]        A,
    input  logic signed [W-1:0]        B,
    input  logic                       wr_en,
    input  logic [$clog2(3*H)-1:0]     wr_addr,
    input  logic signed [W-1:0]        wr_data,
    output logic                       wr_err,
    input  logic                       cnt_clr,
    output logic                       out_valid,
    output logic                       step,
    output logic                       raw_step,
    output logic [CNT_W-1:0]           step_count
);

    localparam int KW = (H > 1) ? $clog2(H) : 1;
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int AW = $clog2(3 * H);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q;
    logic signed [W-1:0]     a_q, b_q;
    logic signed [W-1:0]     wa_w [H];
    logic signed [W-1:0]     wb_w [H];
    logic signed [W-1:0]     al_w [H];
    logic signed [W-1:0]     hid_q [H];
    logic signed [ACC_W-1:0] acc_q;
    logic [GW-1:0]           gap_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    out_valid_q, step_q, raw_q, wr_err_q;

    logic                    accept, last_k, wr_ok, raw_now, step_now;
    logic signed [W-1:0]     mac_a, mac_x, mac_b, mac_y;
    logic signed [ACC_W-1:0] mac_sum, s_shift;
    logic signed [W-1:0]     hid_val;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign last_k   = (k_q == KW'(H - 1));
    assign wr_ok    = wr_en && (state_q == IDLE) && (32'(wr_addr) < 32'(3 * H));

    // Weight banks; each slot only listens to its own address.
    for (genvar gi = 0; gi < H; gi++) begin : g_wt
        logic signed [W-1:0] wa_q, wb_q, al_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wa_q <= '0;
                wb_q <= '0;
                al_q <= '0;
            end else if (wr_ok) begin
                if (wr_addr == AW'(WA_SLOT * H + gi)) wa_q <= wr_data;
                if (wr_addr == AW'(WB_SLOT * H + gi)) wb_q <= wr_data;
                if (wr_addr == AW'(AL_SLOT * H + gi)) al_q <= wr_data;
            end
        end

        assign wa_w[gi] = wa_q;
        assign wb_w[gi] = wb_q;
        assign al_w[gi] = al_q;
    end

    // One MAC serves both layers: A*wa + B*wb in L1, alpha*hid + 0 in L2.
    always_comb begin
        mac_a = a_q;
        mac_x = wa_w[k_q];
        mac_b = b_q;
        mac_y = wb_w[k_q];
        if (state_q == L2) begin
            mac_a = al_w[k_q];
            mac_x = hid_q[k_q];
            mac_b = '0;
            mac_y = '0;
        end
    end

    step_nn_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .a_i   (mac_a),
        .x_i   (mac_x),
        .b_i   (mac_b),
        .y_i   (mac_y),
        .sum_o (mac_sum)
    );

    assign s_shift  = mac_sum >>> FRAC;
    assign hid_val  = W'(relu_sat(64'(s_shift), W));
    assign raw_now  = (acc_q > THRESH);
    assign step_now = raw_now && (gap_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = L1;
            L1:      if (last_k) state_d = L2;
            L2:      if (last_k) state_d = ACT;
            ACT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            step_q      <= 1'b0;
            raw_q       <= 1'b0;
            wr_err_q    <= 1'b0;
            for (int i = 0; i < H; i++) hid_q[i] <= '0;
        end else begin
            out_valid_q <= (state_q == ACT);
            wr_err_q    <= wr_en && !wr_ok;
            if (accept) begin
                a_q <= A;
                b_q <= B;
            end
            if (state_q == L1 || state_q == L2) begin
                k_q <= last_k ? '0 : k_q + 1'b1;
            end
            if (state_q == L1) begin
                hid_q[k_q] <= hid_val;
                // Clear the output accumulator on the way into L2.
                if (last_k) acc_q <= '0;
            end
            if (state_q == L2) begin
                acc_q <= acc_q + mac_sum;
            end
            if (state_q == ACT) begin
                raw_q  <= raw_now;
                step_q <= step_now;
                if (step_now) begin
                    gap_q <= GW'(MIN_GAP - 1);
                end else if (gap_q != '0) begin
                    gap_q <= gap_q - 1'b1;
                end
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (state_q == ACT && step_now && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign step       = step_q;
    assign raw_step   = raw_q;
    assign wr_err     = wr_err_q;
    assign step_count = cnt_q;

endmodule

// File: tb/tb_step_nn_seq.sv
// Self-checking bench for step_nn_seq: directed scenarios plus random samples
// compared against an arithmetic reference of the two-layer network.
module tb_step_nn_seq;

    localparam int W       = 8;
    localparam int H       = 2;
    localparam int ACC_W   = 2 * W + 4;
    localparam int THR     = 10;
    localparam int MIN_GAP = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] A = '0;
    logic signed [W-1:0] B = '0;
    logic                wr_en = 1'b0;
    logic [2:0]          wr_addr = '0;
    logic signed [W-1:0] wr_data = '0;
    logic                cnt_clr = 1'b0;

    logic                in_ready, wr_err, out_valid, step, raw_step;
    logic [15:0]         step_count;
    logic                in_ready2, wr_err2, out_valid2, step2, raw_step2;
    logic [1:0]          step_count2;

    always #5 clk = ~clk;

    step_nn_seq #(
        .W(W), .H(H), .ACC_W(ACC_W), .FRAC(0), .THRESH(20'sd10), .MIN_GAP(MIN_GAP), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .cnt_clr(cnt_clr), .out_valid(out_valid), .step(step), .raw_step(raw_step),
        .step_count(step_count)
    );

    step_nn_seq #(
        .W(W), .H(H), .ACC_W(ACC_W), .FRAC(0), .THRESH(20'sd10), .MIN_GAP(MIN_GAP), .CNT_W(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .A(A), .B(B),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err2),
        .cnt_clr(cnt_clr), .out_valid(out_valid2), .step(step2), .raw_step(raw_step2),
        .step_count(step_count2)
    );

    int wa_m [H];
    int wb_m [H];
    int al_m [H];
    int gap_m = 0;
    int cnt16_m = 0;
    int cnt2_m = 0;
    int checks = 0;
    int failures = 0;
    logic [4:0] hist = '0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_acc(input int a, input int b);
        int acc;
        acc = 0;
        for (int k = 0; k < H; k++) begin
            int s;
            int hid;
            s   = a * wa_m[k] + b * wb_m[k];
            hid = (s < 0) ? 0 : ((s > 127) ? 127 : s);
            acc += al_m[k] * hid;
        end
        return acc;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < H; k++) begin
            wa_m[k] = 0;
            wb_m[k] = 0;
            al_m[k] = 0;
        end
        gap_m   = 0;
        cnt16_m = 0;
        cnt2_m  = 0;
    endtask

    task automatic write_w(input int addr, input int data, input bit exp_err);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = 8'(data);
        tick();
        wr_en = 1'b0;
        check("wr_err", 64'(wr_err), 64'(exp_err));
        if (!exp_err) begin
            if (addr < H) wa_m[addr] = data;
            else if (addr < 2 * H) wb_m[addr - H] = data;
            else al_m[addr - 2 * H] = data;
        end
    endtask

    // n counts the accept cycle as cycle 0; out_valid must appear in cycle 2H+2.
    task automatic run_sample(input int a, input int b, input bit busy_wr, input bit clr);
        int n;
        int exp_acc;
        bit raw_e, step_e;
        A        = 8'(a);
        B        = 8'(b);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        n = 1;
        if (busy_wr) begin
            wr_en   = 1'b1;
            wr_addr = 3'd0;
            wr_data = 8'sd5;
            tick();
            wr_en = 1'b0;
            n++;
            check("wr_err_busy", 64'(wr_err), 64'd1);
        end
        while (!out_valid && n < 40) begin
            if (clr && n == 2 * H + 1) cnt_clr = 1'b1;
            tick();
            cnt_clr = 1'b0;
            n++;
        end

        exp_acc = model_acc(a, b);
        raw_e   = (exp_acc > THR);
        step_e  = raw_e && (gap_m == 0);
        if (step_e) begin
            gap_m   = MIN_GAP - 1;
            cnt16_m = (cnt16_m < 65535) ? cnt16_m + 1 : cnt16_m;
            cnt2_m  = (cnt2_m < 3) ? cnt2_m + 1 : cnt2_m;
        end else if (gap_m > 0) begin
            gap_m--;
        end
        if (clr) begin
            cnt16_m = 0;
            cnt2_m  = 0;
        end

        $display("sample A=%0d B=%0d acc=%0d raw=%0b step=%0b count=%0d latency=%0d",
                 a, b, u_dut.acc_q, raw_step, step, step_count, n);
        check("latency", 64'(n), 64'(2 * H + 2));
        check("in_ready_at_out", 64'(in_ready), 64'd1);
        check("acc", 64'(u_dut.acc_q), 64'(exp_acc));
        check("raw_step", 64'(raw_step), 64'(raw_e));
        check("step", 64'(step), 64'(step_e));
        check("step_count", 64'(step_count), 64'(cnt16_m));
        check("step_count2", 64'(step_count2), 64'(cnt2_m));
        hist = {hist[3:0], step};
    endtask

    initial begin
        int pulses;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_step", 64'(step), 64'd0);
        check("rst_raw_step", 64'(raw_step), 64'd0);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        check("rst_step_count", 64'(step_count), 64'd0);
        check("rst_acc", 64'(u_dut.acc_q), 64'd0);

        // wa=(1,-1) wb=(2,1) alpha=(2,-3)
        write_w(0, 1, 1'b0);
        write_w(1, -1, 1'b0);
        write_w(2, 2, 1'b0);
        write_w(3, 1, 1'b0);
        write_w(4, 2, 1'b0);
        write_w(5, -3, 1'b0);

        run_sample(3, 4, 1'b0, 1'b0);
        check("ex_acc19", 64'(u_dut.acc_q), 64'd19);
        tick();
        check("out_valid_pulse", 64'(out_valid), 64'd0);
        check("step_held", 64'(step), 64'd1);

        run_sample(4, 1, 1'b0, 1'b0);
        check("relu_acc12", 64'(u_dut.acc_q), 64'd12);
        run_sample(127, 127, 1'b0, 1'b0);
        check("clamp_acc254", 64'(u_dut.acc_q), 64'd254);

        // Let the debounce window drain, then five back-to-back steps.
        repeat (3) run_sample(0, 0, 1'b0, 1'b0);
        repeat (5) run_sample(3, 4, 1'b0, 1'b0);
        check("debounce_pattern", 64'(hist), 64'(5'b10001));

        run_sample(3, 4, 1'b1, 1'b0);
        write_w(6, 9, 1'b1);
        tick();
        check("wr_err_clears", 64'(wr_err), 64'd0);
        write_w(7, 9, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_sample(3, 4, 1'b0, 1'b0);
            repeat (3) run_sample(0, 0, 1'b0, 1'b0);
        end
        check("cnt2_saturated", 64'(step_count2), 64'd3);

        run_sample(3, 4, 1'b0, 1'b1);
        check("clr_beats_inc", 64'(step_count), 64'd0);

        for (int i = 0; i < 15; i++) begin
            if (i % 5 == 0) begin
                for (int j = 0; j < 3 * H; j++) begin
                    write_w(j, int'($urandom_range(0, 255)) - 128, 1'b0);
                end
            end
            run_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                       1'b0, 1'b0);
        end

        // Abort an inference in L2 with reset.
        A        = 8'sd3;
        B        = 8'sd4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_step_count", 64'(step_count), 64'd0);
        check("midrst_step", 64'(step), 64'd0);
        tick();
        rst = 1'b0;
        model_reset();
        pulses = 0;
        repeat (10) begin
            tick();
            if (out_valid) pulses++;
        end
        check("midrst_no_out_valid", 64'(pulses), 64'd0);
        run_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                   1'b0, 1'b0);
        check("midrst_acc_zero", 64'(u_dut.acc_q), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
